// File: rtl/operand_entry.sv
// Keypad operand capture: debounced key events build two decimal operands A and B, which are
// then offered to the multiplier over valid/ready. Optional echo ports: OPERAND_ENTRY_ECHO_EN.
module operand_entry #(
  parameter int unsigned W          = 8,
  parameter int unsigned MAX_DIGITS = 3,
  localparam int unsigned CntW      = $clog2(MAX_DIGITS + 1)
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [3:0]      key_code,
  input  logic            data_available,
  input  logic            key_valid,
  input  logic            op_ready,
  output logic [W-1:0]    op_a,
  output logic [W-1:0]    op_b,
  output logic            op_valid,
  output logic            entering_b,
  output logic            err,
`ifdef OPERAND_ENTRY_ECHO_EN
  output logic [3:0]      last_key,
  output logic [0:0]      key_strobe,
`endif
  output logic [CntW-1:0] digit_cnt
);

  localparam int unsigned     ExtW    = W + 4;
  localparam logic [ExtW-1:0] MaxVal  = {4'b0000, {W{1'b1}}};
  localparam logic [CntW-1:0] CntFull = CntW'(MAX_DIGITS);

  localparam logic [3:0] KeyEnter = 4'hA;
  localparam logic [3:0] KeyClear = 4'hC;
  localparam logic [3:0] KeyAbort = 4'hD;

  typedef enum logic [1:0] {
    StEnterA  = 2'd0,
    StEnterB  = 2'd1,
    StWaitAck = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic            op_valid_q, op_valid_d;
  logic            err_q, err_d;
  logic [CntW-1:0] digit_cnt_q, digit_cnt_d;
  logic            da_q;

  logic            key_event;
  logic            ev_digit, ev_enter, ev_clear, ev_abort;
  logic            in_entry;
  logic            enter_ok;
  logic            handshake;
  logic [W-1:0]    acc;
  logic [ExtW-1:0] acc_next;

  // Rising edge of the debouncer flag, qualified by a key being physically down.
  assign key_event = data_available & ~da_q & key_valid;

  assign ev_digit  = key_event && (key_code <= 4'd9);
  assign ev_enter  = key_event && (key_code == KeyEnter);
  assign ev_clear  = key_event && (key_code == KeyClear);
  assign ev_abort  = key_event && (key_code == KeyAbort);

  assign in_entry  = (state_q == StEnterA) || (state_q == StEnterB);
  assign enter_ok  = ev_enter && in_entry && (digit_cnt_q != '0);
  assign handshake = (state_q == StWaitAck) && op_valid_q && op_ready;

  // The operand currently being typed.
  assign acc       = (state_q == StEnterB) ? op_b_q : op_a_q;
  assign acc_next  = ({4'b0000, acc} * ExtW'(10)) + ExtW'(key_code);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StEnterA;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEnterA:  if (enter_ok)  state_d = StEnterB;
      StEnterB:  if (enter_ok)  state_d = StWaitAck;
      StWaitAck: if (handshake) state_d = StEnterA;
      default:                  state_d = StEnterA;
    endcase
    // Abort overrides everything, including a same-edge handshake.
    if (ev_abort) begin
      state_d = StEnterA;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_valid_d  = op_valid_q;
    err_d       = err_q;
    digit_cnt_d = digit_cnt_q;

    if (ev_abort) begin
      op_a_d      = '0;
      op_b_d      = '0;
      op_valid_d  = 1'b0;
      err_d       = 1'b0;
      digit_cnt_d = '0;
    end else if (state_q == StWaitAck) begin
      if (handshake) begin
        op_a_d      = '0;
        op_b_d      = '0;
        op_valid_d  = 1'b0;
        digit_cnt_d = '0;
      end
    end else if (ev_digit) begin
      if (digit_cnt_q == CntFull) begin
        // Digit budget exhausted: silently dropped.
      end else if (acc_next > MaxVal) begin
        err_d = 1'b1;
      end else begin
        if (state_q == StEnterB) begin
          op_b_d = acc_next[W-1:0];
        end else begin
          op_a_d = acc_next[W-1:0];
        end
        digit_cnt_d = digit_cnt_q + CntW'(1);
      end
    end else if (ev_enter) begin
      if (enter_ok) begin
        digit_cnt_d = '0;
        err_d       = 1'b0;
        if (state_q == StEnterB) begin
          op_valid_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (ev_clear) begin
      if (state_q == StEnterB) begin
        op_b_d = '0;
      end else begin
        op_a_d = '0;
      end
      digit_cnt_d = '0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      digit_cnt_q <= '0;
      da_q        <= 1'b0;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_valid_q  <= op_valid_d;
      err_q       <= err_d;
      digit_cnt_q <= digit_cnt_d;
      da_q        <= data_available;
    end
  end

`ifdef OPERAND_ENTRY_ECHO_EN
  logic [3:0] last_key_q, last_key_d;
  logic       key_strobe_q, key_strobe_d;

  always_comb begin
    last_key_d   = last_key_q;
    key_strobe_d = key_event;
    if (key_event) begin
      last_key_d = key_code;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      last_key_q   <= 4'h0;
      key_strobe_q <= 1'b0;
    end else begin
      last_key_q   <= last_key_d;
      key_strobe_q <= key_strobe_d;
    end
  end

  assign last_key   = last_key_q;
  assign key_strobe = key_strobe_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a       = op_a_q;
    op_b       = op_b_q;
    op_valid   = op_valid_q;
    err        = err_q;
    digit_cnt  = digit_cnt_q;
    entering_b = (state_q == StEnterB);
  end

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed scenarios followed by random key traffic,
// all compared against an arithmetic model of the entry rules.
module tb_operand_entry;

  localparam int unsigned W    = 8;
  localparam int unsigned MAXD = 3;
  localparam int unsigned CntW = $clog2(MAXD + 1);
  localparam int          MAXV = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            n_reset;
  logic [3:0]      key_code;
  logic            data_available;
  logic            key_valid;
  logic            op_ready;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            op_valid;
  logic            entering_b;
  logic            err;
  logic [CntW-1:0] digit_cnt;
`ifdef OPERAND_ENTRY_ECHO_EN
  logic [3:0]      last_key;
  logic [0:0]      key_strobe;
`endif

  int vectors;
  int miscompares;

  // Model: stage 0 = typing A, 1 = typing B, 2 = offering the pair.
  int m_stage;
  int m_a;
  int m_b;
  int m_cnt;
  int m_err;
  int m_valid;
  int m_last;

  operand_entry #(
    .W          (W),
    .MAX_DIGITS (MAXD)
  ) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .key_code       (key_code),
    .data_available (data_available),
    .key_valid      (key_valid),
    .op_ready       (op_ready),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_valid       (op_valid),
    .entering_b     (entering_b),
    .err            (err),
`ifdef OPERAND_ENTRY_ECHO_EN
    .last_key       (last_key),
    .key_strobe     (key_strobe),
`endif
    .digit_cnt      (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stage = 0; m_a = 0; m_b = 0; m_cnt = 0; m_err = 0; m_valid = 0; m_last = 0;
  endtask

  task automatic model_key(input int k);
    int cur;
    int nxt;
    m_last = k;
    if (k == 13) begin
      m_a = 0; m_b = 0; m_cnt = 0; m_err = 0; m_valid = 0; m_stage = 0;
    end else if (m_stage == 2) begin
      // Pair on offer: only abort matters.
    end else if (k <= 9) begin
      cur = (m_stage == 0) ? m_a : m_b;
      if (m_cnt < MAXD) begin
        nxt = cur * 10 + k;
        if (nxt > MAXV) m_err = 1;
        else begin
          if (m_stage == 0) m_a = nxt; else m_b = nxt;
          m_cnt++;
        end
      end
    end else if (k == 10) begin
      if (m_cnt == 0) m_err = 1;
      else begin
        m_cnt = 0; m_err = 0;
        if (m_stage == 0) m_stage = 1;
        else begin m_stage = 2; m_valid = 1; end
      end
    end else if (k == 12) begin
      if (m_stage == 0) m_a = 0; else m_b = 0;
      m_cnt = 0; m_err = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".op_a"},       32'(op_a),       32'(m_a));
    chk({tag, ".op_b"},       32'(op_b),       32'(m_b));
    chk({tag, ".op_valid"},   32'(op_valid),   32'(m_valid));
    chk({tag, ".entering_b"}, 32'(entering_b), 32'(m_stage == 1));
    chk({tag, ".err"},        32'(err),        32'(m_err));
    chk({tag, ".digit_cnt"},  32'(digit_cnt),  32'(m_cnt));
`ifdef OPERAND_ENTRY_ECHO_EN
    chk({tag, ".last_key"},   32'(last_key),   32'(m_last));
`endif
  endtask

  // Called at a negedge; returns at a negedge after the key has been released.
  task automatic press(input int k, input int hold, input logic rdy);
    key_code       = 4'(k);
    key_valid      = 1'b1;
    data_available = 1'b1;
    op_ready       = rdy;
    model_key(k);
    repeat (hold) @(negedge clk);
    data_available = 1'b0;
    key_valid      = 1'b0;
    op_ready       = 1'b0;
    key_code       = 4'($urandom_range(0, 15));
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_ready();
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    if (m_valid != 0) begin
      m_valid = 0; m_a = 0; m_b = 0; m_cnt = 0; m_stage = 0;
    end
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    #2 n_reset = 1'b0;
    #1;
    model_reset();
    chk({tag, ".op_a"},       32'(op_a),       32'd0);
    chk({tag, ".op_b"},       32'(op_b),       32'd0);
    chk({tag, ".op_valid"},   32'(op_valid),   32'd0);
    chk({tag, ".entering_b"}, 32'(entering_b), 32'd0);
    chk({tag, ".err"},        32'(err),        32'd0);
    chk({tag, ".digit_cnt"},  32'(digit_cnt),  32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    n_reset = 1'b0; key_code = 4'h0; data_available = 1'b0; key_valid = 1'b0; op_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_model("reset");
    n_reset = 1'b1;
    @(negedge clk);

    // Basic entry of 12 x 3 and handshake.
    press(1, 10, 1'b0); press(2, 10, 1'b0); press(10, 10, 1'b0);
    check_model("a_done");
    chk("a_done.entering_b_const", 32'(entering_b), 32'd1);
    press(3, 10, 1'b0); press(10, 10, 1'b0);
    check_model("pair");
    chk("pair.op_a_const", 32'(op_a), 32'd12);
    chk("pair.op_b_const", 32'(op_b), 32'd3);
    pulse_ready();
    check_model("ack");

    // Overflowing digit rejected, then clear.
    press(2, 3, 1'b0); press(5, 3, 1'b0); press(6, 3, 1'b0);
    check_model("ovf");
    chk("ovf.op_a_const", 32'(op_a), 32'd25);
    chk("ovf.err_const",  32'(err),  32'd1);
    press(12, 3, 1'b0);
    check_model("clear");

    // Leading zeros fill the digit budget; fourth digit dropped quietly.
    press(0, 2, 1'b0); press(0, 2, 1'b0); press(0, 2, 1'b0); press(7, 2, 1'b0);
    check_model("max_digits");
    press(12, 1, 1'b0);

    // Long hold gives one event; idle level without key_valid gives none.
    press(5, 20, 1'b0);
    check_model("long_hold");
    key_code = 4'd7; key_valid = 1'b0; data_available = 1'b1;
    repeat (10) @(negedge clk);
    key_valid = 1'b1;
    repeat (5) @(negedge clk);
    data_available = 1'b0; key_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_model("idle_level");
    press(12, 1, 1'b0);

    // Enter with nothing typed; then abort racing a ready in WAIT_ACK.
    press(10, 2, 1'b0);
    check_model("empty_enter");
    press(9, 2, 1'b0); press(10, 2, 1'b0); press(9, 2, 1'b0); press(10, 2, 1'b0);
    check_model("pair2");
    press(13, 1, 1'b1);
    check_model("abort_vs_ready");

    // Reset mid-entry of B, re-entry, reset while pair on offer.
    press(1, 2, 1'b0); press(2, 2, 1'b0); press(10, 2, 1'b0);
    check_model("pre_reset");
    async_reset("rst_entry");
    press(4, 2, 1'b0); press(10, 2, 1'b0); press(4, 2, 1'b0); press(10, 2, 1'b0);
    check_model("post_reset_pair");
    async_reset("rst_wait");
    check_model("rst_wait_after");

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      int r;
      int k;
      r = $urandom_range(0, 99);
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 70) k = 10;
      else if (r < 77) k = 12;
      else if (r < 81) k = 13;
      else if (r < 86) k = (r == 81) ? 11 : ((r < 84) ? 14 : 15);
      else             k = -1;
      if (k >= 0) begin
        press(k, $urandom_range(1, 5), 1'b0);
      end else begin
        pulse_ready();
      end
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
